// File: rtl/base_digit_shifter_pkg.sv
// Shared constants and helpers for the base converter: base_sel encodings,
// FSM state encoding, and digit width / digit count helpers.
package base_conv_pkg;

    localparam logic [1:0] BASE_BIN = 2'b00;
    localparam logic [1:0] BASE_OCT = 2'b01;
    localparam logic [1:0] BASE_HEX = 2'b10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    // Bits per digit for a base selection; the reserved code falls back to binary.
    function automatic logic [2:0] digit_width(input logic [1:0] base_sel);
        case (base_sel)
            BASE_OCT: digit_width = 3'd3;
            BASE_HEX: digit_width = 3'd4;
            default:  digit_width = 3'd1;
        endcase
    endfunction

    // Number of digits needed to cover width bits at dw bits per digit (rounded up).
    function automatic int num_digits(input int width, input int dw);
        num_digits = (width + dw - 1) / dw;
    endfunction

endpackage

// File: rtl/base_digit_shifter_if.sv
// Load and digit handshake bundle between the operand producer / digit consumer
// (master) and the digit shifter (slave).
interface base_digit_shifter_if #(
    parameter int WIDTH   = 12,
    parameter int DIGIT_W = 4
);
    logic               load_valid;
    logic               load_ready;
    logic [WIDTH-1:0]   load_data;
    logic [1:0]         base_sel;
    logic               digit_valid;
    logic               digit_ready;
    logic [DIGIT_W-1:0] digit_data;
    logic               digit_last;

    modport master (
        output load_valid, load_data, base_sel, digit_ready,
        input  load_ready, digit_valid, digit_data, digit_last
    );

    modport slave (
        input  load_valid, load_data, base_sel, digit_ready,
        output load_ready, digit_valid, digit_data, digit_last
    );
endinterface

// File: rtl/base_digit_shifter.sv
// Captures an operand and serialises it into binary/octal/hex digits, LSD first.
// The register shifts right by the latched digit width on every accepted digit,
// so the current digit is always the low bits of the register.
module base_digit_shifter
    import base_conv_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int DIGIT_W = 4,
    parameter int CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    base_digit_shifter_if.slave  bus,
    output logic                 busy,
    output logic [WIDTH-1:0]     q
);

    localparam logic [CNT_W-1:0] ND_BIN = CNT_W'(num_digits(WIDTH, int'(digit_width(BASE_BIN))));
    localparam logic [CNT_W-1:0] ND_OCT = CNT_W'(num_digits(WIDTH, int'(digit_width(BASE_OCT))));
    localparam logic [CNT_W-1:0] ND_HEX = CNT_W'(num_digits(WIDTH, int'(digit_width(BASE_HEX))));

    logic [0:0]       state_reg;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] count_reg;
    logic [2:0]       dw_reg;

    logic             emit;
    logic [3:0]       digit_nib;
    logic [WIDTH-1:0] data_shifted;
    logic [2:0]       load_dw;
    logic [CNT_W-1:0] load_count;

    assign emit = (state_reg == ST_EMIT);

    // Current digit and next register value, selected by the latched digit width.
    always_comb begin
        digit_nib    = {3'b000, data_reg[0]};
        data_shifted = data_reg >> 1;
        case (dw_reg)
            3'd3: begin
                digit_nib    = {1'b0, data_reg[2:0]};
                data_shifted = data_reg >> 3;
            end
            3'd4: begin
                digit_nib    = data_reg[3:0];
                data_shifted = data_reg >> 4;
            end
            default: begin
                digit_nib    = {3'b000, data_reg[0]};
                data_shifted = data_reg >> 1;
            end
        endcase
    end

    // Digit width and digit count to latch when an operand is accepted.
    always_comb begin
        load_dw = digit_width(bus.base_sel);
        case (bus.base_sel)
            BASE_OCT: load_count = ND_OCT;
            BASE_HEX: load_count = ND_HEX;
            default:  load_count = ND_BIN;
        endcase
    end

    // FSM, shift register, digit counter and digit width; clear beats both handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            data_reg  <= '0;
            count_reg <= '0;
            dw_reg    <= 3'd1;
        end else if (clear) begin
            state_reg <= ST_IDLE;
            data_reg  <= '0;
            count_reg <= '0;
            dw_reg    <= 3'd1;
        end else if (state_reg == ST_IDLE) begin
            if (bus.load_valid) begin
                state_reg <= ST_EMIT;
                data_reg  <= bus.load_data;
                count_reg <= load_count;
                dw_reg    <= load_dw;
            end
        end else if (bus.digit_ready) begin
            data_reg  <= data_shifted;
            count_reg <= count_reg - 1'b1;
            if (count_reg == CNT_W'(1)) begin
                state_reg <= ST_IDLE;
            end
        end
    end

    assign bus.load_ready  = !emit;
    assign bus.digit_valid = emit;
    assign bus.digit_data  = emit ? DIGIT_W'(digit_nib) : '0;
    assign bus.digit_last  = emit && (count_reg == CNT_W'(1));
    assign busy            = emit;
    assign q               = data_reg;

endmodule

// File: tb/tb_base_digit_shifter.sv
// Directed bench for base_digit_shifter: a 12-bit instance for the hex, octal,
// binary, backpressure and abort cases, and a 10-bit instance for padded top digits.
module tb_base_digit_shifter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_a = 1'b0;
    logic clear_b = 1'b0;
    logic busy_a, busy_b;
    logic [11:0] q_a;
    logic [9:0]  q_b;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int last_cnt = 0;

    always #5 clk = ~clk;

    base_digit_shifter_if #(.WIDTH(12), .DIGIT_W(4)) ia ();
    base_digit_shifter_if #(.WIDTH(10), .DIGIT_W(4)) ib ();

    base_digit_shifter #(.WIDTH(12), .DIGIT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear_a), .bus(ia), .busy(busy_a), .q(q_a)
    );

    base_digit_shifter #(.WIDTH(10), .DIGIT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear_b), .bus(ib), .busy(busy_b), .q(q_b)
    );

    // Count completed digit handshakes and final-digit handshakes on the 12-bit instance.
    always @(posedge clk) begin
        if (ia.digit_valid && ia.digit_ready) hs_cnt++;
        if (ia.digit_valid && ia.digit_ready && ia.digit_last) last_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [11:0] d, input logic [1:0] bs);
        ia.load_data  = d;
        ia.base_sel   = bs;
        ia.load_valid = 1'b1;
        tick();
        ia.load_valid = 1'b0;
    endtask

    // Consume n digits with digit_ready high; seq holds the expected digits, LSD in the low nibble.
    task automatic run_a(input string tag, input logic [63:0] seq, input int n,
                         input int q_idx, input logic [11:0] q_exp);
        ia.digit_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == q_idx) check({tag, "_q"}, 32'(q_a), 32'(q_exp));
            check({tag, "_valid"}, 32'(ia.digit_valid), 32'd1);
            check({tag, "_data"}, 32'(ia.digit_data), 32'(seq[4*i +: 4]));
            check({tag, "_last"}, 32'(ia.digit_last), 32'(i == n - 1));
            tick();
        end
        check({tag, "_ready_back"}, 32'(ia.load_ready), 32'd1);
        check({tag, "_valid_off"}, 32'(ia.digit_valid), 32'd0);
        $display("%s: %0d digits consumed", tag, n);
    endtask

    task automatic run_b(input string tag, input logic [9:0] d, input logic [15:0] seq);
        ib.load_data   = d;
        ib.base_sel    = 2'b01;
        ib.digit_ready = 1'b1;
        ib.load_valid  = 1'b1;
        tick();
        ib.load_valid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_valid"}, 32'(ib.digit_valid), 32'd1);
            check({tag, "_data"}, 32'(ib.digit_data), 32'(seq[4*i +: 4]));
            check({tag, "_last"}, 32'(ib.digit_last), 32'(i == 3));
            tick();
        end
        check({tag, "_ready_back"}, 32'(ib.load_ready), 32'd1);
        $display("%s: operand %0h emitted 4 octal digits", tag, d);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_q"}, 32'(q_a), 32'd0);
        check({tag, "_load_ready"}, 32'(ia.load_ready), 32'd1);
        check({tag, "_digit_valid"}, 32'(ia.digit_valid), 32'd0);
        check({tag, "_digit_data"}, 32'(ia.digit_data), 32'd0);
        check({tag, "_digit_last"}, 32'(ia.digit_last), 32'd0);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
    endtask

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc0;
        ia.load_valid = 1'b0; ia.load_data = '0; ia.base_sel = 2'b00; ia.digit_ready = 1'b1;
        ib.load_valid = 1'b0; ib.load_data = '0; ib.base_sel = 2'b00; ib.digit_ready = 1'b1;

        repeat (2) tick();
        check_reset_values("rst");
        rst_n = 1'b1;
        tick();
        check_reset_values("idle");
        $display("reset: outputs at reset values");

        // 1: hex
        load_a(12'hABC, 2'b10);
        check("hex_busy", 32'(busy_a), 32'd1);
        check("hex_load_ready", 32'(ia.load_ready), 32'd0);
        run_a("hex", 64'hABC, 3, -1, 12'h000);

        // 2: octal, register contents after two digits
        load_a(12'o7351, 2'b01);
        run_a("oct", 64'h7351, 4, 2, 12'o0073);

        // 3: reserved base treated as binary
        load_a(12'h805, 2'b11);
        run_a("bin", 64'h100000000101, 12, -1, 12'h000);

        // 4: backpressure on digit 2, with load_valid and base_sel toggled while busy
        hs_cnt = 0;
        load_a(12'h123, 2'b10);
        check("bp_d0", 32'(ia.digit_data), 32'h3);
        tick();
        ia.digit_ready = 1'b0;
        ia.load_valid  = 1'b1;
        ia.load_data   = 12'hFFF;
        ia.base_sel    = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_data", 32'(ia.digit_data), 32'h2);
            check("bp_hold_valid", 32'(ia.digit_valid), 32'd1);
            check("bp_hold_q", 32'(q_a), 32'h012);
        end
        ia.load_valid  = 1'b0;
        ia.digit_ready = 1'b1;
        tick();
        check("bp_d2", 32'(ia.digit_data), 32'h1);
        check("bp_d2_last", 32'(ia.digit_last), 32'd1);
        tick();
        check("bp_idle", 32'(ia.load_ready), 32'd1);
        check("bp_handshakes", 32'(hs_cnt), 32'd3);
        $display("backpressure: %0d handshakes", hs_cnt);

        // 5a: clear during the second octal digit
        load_a(12'o7351, 2'b01);
        tick();
        check("clr_d1", 32'(ia.digit_data), 32'h5);
        lc0 = last_cnt;
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        check_reset_values("clr");
        tick();
        check("clr_no_last", 32'(last_cnt), 32'(lc0));
        $display("clear: aborted mid-emit");

        // 5b: asynchronous reset pulse mid-emit
        load_a(12'hABC, 2'b10);
        tick();
        check("arst_pre", 32'(ia.digit_data), 32'hB);
        #2 rst_n = 1'b0;
        #1 check_reset_values("arst");
        #2 rst_n = 1'b1;
        tick();
        check_reset_values("arst_after");
        $display("async reset: outputs cleared before next edge");

        load_a(12'h5E7, 2'b10);
        run_a("post", 64'h5E7, 3, -1, 12'h000);

        // 6: 10-bit instance, octal padded top digit and zero operand
        run_b("w10_ones", 10'h3FF, 16'h1777);
        run_b("w10_zero", 10'h000, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
